inert_sensor_spi_rsp: RTL



---
 rtl/inert_sensor_spi_rsp.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/inert_sensor_spi_rsp.sv
// inert_sensor_spi_rsp: SPI mode-3 responder model of the inertial sensor with config regs, sample snapshots and INT.
// Optional SAMPLE_RAMP_EN: snapshot sources come from internal ramps instead of ptch_rt_in/az_in.
module inert_sensor_spi_rsp #(
    parameter int          INT_PERIOD   = 240385,
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] ptch_rt_in,
    input  logic [15:0] az_in,
    output logic        int_en
);
    localparam int TW = $clog2(INT_PERIOD + 1);
    logic [2:0]    ss_q, sclk_q;
    logic [1:0]    mosi_q;
    logic [4:0]    cnt_q, cnt_d;
    logic [15:0]   rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    int1_q, int1_d, ctrl1_q, ctrl1_d, ctrl2_q, ctrl2_d, ctrl5_q, ctrl5_d;
    logic [7:0]    p_lo_q, p_lo_d, p_hi_q, p_hi_d, a_lo_q, a_lo_d, a_hi_q, a_hi_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d, snap_q, int_q, int_d;
    logic          ss_fall, ss_rise, sclk_rise, sclk_fall, ss_act, shift, rd8, wr, run, tc, snap;
    logic [6:0]    addr8, wa;
    logic [7:0]    wd, rd_data;
    logic [15:0]   src_p, src_a;

    // Edges come from the 2nd/3rd synchronizer stages so they line up with mosi_q[1]
    assign ss_fall   = ss_q[2] & ~ss_q[1];
    assign ss_rise   = ~ss_q[2] & ss_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign ss_act    = ~ss_q[1];
    assign shift     = sclk_rise & ss_act;
    assign addr8     = {rx_q[5:0], mosi_q[1]};
    assign rd8       = shift & (cnt_q == 5'd7) & rx_q[6];
    assign wr        = ss_rise & (cnt_q == 5'd16) & ~rx_q[15];
    assign wa        = rx_q[14:8];
    assign wd        = rx_q[7:0];
    assign run       = |ctrl1_q & |ctrl2_q;
    assign tc        = run & (tmr_q == TW'(INT_PERIOD - 1));
    // A due snapshot waits out any frame in progress so read pairs stay coherent
    assign snap      = (tc | pend_q) & ~ss_act;

    always_comb begin
        case (addr8)
            7'h0D:   rd_data = int1_q;
            7'h0F:   rd_data = WHO_AM_I_VAL;
            7'h10:   rd_data = ctrl1_q;
            7'h11:   rd_data = ctrl2_q;
            7'h14:   rd_data = ctrl5_q;
            7'h22:   rd_data = p_lo_q;
            7'h23:   rd_data = p_hi_q;
            7'h2C:   rd_data = a_lo_q;
            7'h2D:   rd_data = a_hi_q;
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        rx_d    = ss_fall ? 16'h0 : shift ? {rx_q[14:0], mosi_q[1]} : rx_q;
        cnt_d   = ss_fall ? 5'd0 : (shift && cnt_q != 5'd16) ? cnt_q + 5'd1 : cnt_q;
        tx_d    = ss_fall ? 8'h0 : rd8 ? rd_data :
                  (sclk_fall && ss_act && cnt_q >= 5'd9) ? {tx_q[6:0], 1'b0} : tx_q;
        int1_d  = (wr && wa == 7'h0D) ? wd : int1_q;
        ctrl1_d = (wr && wa == 7'h10) ? wd : ctrl1_q;
        ctrl2_d = (wr && wa == 7'h11) ? wd : ctrl2_q;
        ctrl5_d = (wr && wa == 7'h14) ? wd : ctrl5_q;
        tmr_d   = !run ? tmr_q : tc ? '0 : tmr_q + 1'b1;
        pend_d  = (tc | pend_q) & ss_act;
        p_lo_d  = snap ? src_p[7:0]  : p_lo_q;
        p_hi_d  = snap ? src_p[15:8] : p_hi_q;
        a_lo_d  = snap ? src_a[7:0]  : a_lo_q;
        a_hi_d  = snap ? src_a[15:8] : a_hi_q;
        int_d   = (snap_q & int1_q[1]) |
                  (int_q & ~((rd8 && addr8 == 7'h22) || (wr && wa == 7'h0D && !wd[1])));
    end

`ifdef SAMPLE_RAMP_EN
    logic [15:0] rp_q, ra_q;
    assign src_p = rp_q;
    assign src_a = ra_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp_q <= 16'h0000;
            ra_q <= 16'h4000;
        end else if (snap) begin
            rp_q <= rp_q + 16'h1;
            ra_q <= ra_q - 16'h1;
        end
    end
`else
    assign src_p = ptch_rt_in;
    assign src_a = az_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_q    <= 3'b111;
            sclk_q  <= 3'b111;
            mosi_q  <= 2'b00;
            cnt_q   <= 5'd0;
            rx_q    <= 16'h0;
            tx_q    <= 8'h0;
            int1_q  <= 8'h0;
            ctrl1_q <= 8'h0;
            ctrl2_q <= 8'h0;
            ctrl5_q <= 8'h0;
            p_lo_q  <= 8'h0;
            p_hi_q  <= 8'h0;
            a_lo_q  <= 8'h0;
            a_hi_q  <= 8'h0;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
            snap_q  <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            ss_q    <= {ss_q[1:0], SS_n};
            sclk_q  <= {sclk_q[1:0], SCLK};
            mosi_q  <= {mosi_q[0], MOSI};
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            int1_q  <= int1_d;
            ctrl1_q <= ctrl1_d;
            ctrl2_q <= ctrl2_d;
            ctrl5_q <= ctrl5_d;
            p_lo_q  <= p_lo_d;
            p_hi_q  <= p_hi_d;
            a_lo_q  <= a_lo_d;
            a_hi_q  <= a_hi_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            snap_q  <= snap;
            int_q   <= int_d;
        end
    end

    assign MISO   = tx_q[7];
    assign INT    = int_q;
    assign int_en = int1_q[1];
endmodule
